// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared FSM encoding, tag constants and throttle LFSR step
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam int INVALID_TAG  = 0;
    localparam int DATA_TAG     = 1;
    localparam int DATA_END_TAG = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/mem_responder_pipe.sv
// rtl/mem_responder_pipe.sv - fixed-latency valid/data delay line; payload holds when no valid passes
module mem_responder_pipe #(
    parameter int LATENCY = 3,
    parameter int WIDTH   = 36
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q  [LATENCY];
    logic [LATENCY-1:0] valid_in;
    logic [WIDTH-1:0]   data_in [LATENCY];

    always_comb begin
        valid_in   = LATENCY'({valid_q, valid_i});
        data_in[0] = data_i;
        for (int i = 1; i < LATENCY; i++) begin
            data_in[i] = data_q[i-1];
        end
    end

    // Each stage only captures real reads so the last stage keeps the previous result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_in;
            for (int i = 0; i < LATENCY; i++) begin
                if (valid_in[i]) begin
                    data_q[i] <= data_in[i];
                end
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - pipelined word memory responder; MEM_RESPONDER_THROTTLE_EN adds LFSR ready throttling
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 4,
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     request_i,
    input  logic                     command_entry_i,
    input  logic                     write_enable_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic [TAG_WIDTH-1:0]     tag_i,
    input  logic [DATA_WIDTH-1:0]    data_in_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    query_o,
    output logic [TAG_WIDTH-1:0]     qtag_o,
    output logic                     addr_error_o
);

    localparam int CNT_W  = $clog2(READ_LATENCY + 1);
    localparam int PIPE_W = TAG_WIDTH + DATA_WIDTH;

    state_e                  state_q, state_d;
    logic                    ready_q, addr_error_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   mem_q [2**DEPTH_LOG2];
    logic                    accept, accept_rd, in_range, throttle;
    logic [DEPTH_LOG2-1:0]   index;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    pipe_valid;
    logic [PIPE_W-1:0]       pipe_data;

    assign accept    = ready_q & command_entry_i & request_i;
    assign accept_rd = accept & ~write_enable_i;
    assign in_range  = (address_i >> DEPTH_LOG2) == '0;
    assign index     = address_i[DEPTH_LOG2-1:0];
    assign rd_word   = in_range ? mem_q[index] : '0;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (accept && write_enable_i && in_range) begin
            mem_q[index] <= data_in_i;
        end
    end

`ifdef MEM_RESPONDER_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d   = lfsr_step(lfsr_q);
    assign throttle = lfsr_d[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign throttle = 1'b0;
`endif

    assign count_d = count_q + CNT_W'(accept_rd) - CNT_W'(pipe_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (request_i) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!request_i) state_d = (count_d != '0) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (request_i)            state_d = ST_ACTIVE;
                else if (count_d == '0)   state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Leaving IDLE costs one extra edge before ready can rise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            count_q      <= '0;
            addr_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q != ST_IDLE) && (state_d == ST_ACTIVE) && !throttle;
            count_q <= count_d;
            if (accept && !in_range) begin
                addr_error_q <= 1'b1;
            end
        end
    end

    mem_responder_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (PIPE_W)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (accept_rd),
        .data_i  ({tag_i, rd_word}),
        .valid_o (pipe_valid),
        .data_o  (pipe_data)
    );

    assign ready_o      = ready_q;
    assign valid_o      = pipe_valid;
    assign query_o      = pipe_data[DATA_WIDTH-1:0];
    assign qtag_o       = pipe_data[PIPE_W-1:DATA_WIDTH];
    assign addr_error_o = addr_error_q;

endmodule
